// File: rtl/mcu_sim_supervisor.sv
// mcu_sim_supervisor: supervisor wrapped around the mcu under simulation.
// Sequences the mcu reset, buffers tty characters in a first-word-fall-through
// FIFO drained through a ready/valid port, and ends the run on a LED pass/fail
// signature or when the run-cycle watchdog expires.
`timescale 1ns/1ps
module mcu_sim_supervisor #(
  parameter int          TTY_W      = 7,
  parameter int          LED_W      = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter int          RST_CYCLES = 5,
  parameter int          TIMEOUT    = 5000,
  parameter logic [31:0] PASS_SIG   = 32'h600D_600D,
  parameter logic [31:0] FAIL_SIG   = 32'hBAD0_BAD0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             dut_rst_no,
  input  logic [TTY_W-1:0] tty_i,
  input  logic             tty_we_i,
  input  logic [LED_W-1:0] led_i,
  output logic [TTY_W-1:0] tty_data_o,
  output logic             tty_valid_o,
  input  logic             tty_ready_i,
  output logic             tty_drop_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RST_CYCLES + 1);

  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // With TIMEOUT == 0 this value is unused: the watchdog branch is disabled.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [LED_W-1:0] PASS_V    = LED_W'(PASS_SIG);
  localparam logic [LED_W-1:0] FAIL_V    = LED_W'(FAIL_SIG);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [AW:0]      FILL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]      FILL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [TTY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fill;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            drop_now;

  // Characters are only captured while the mcu is actually running; a push
  // into a full FIFO is still legal when the head leaves in the same cycle.
  assign fifo_full   = (fill == FILL_FULL);
  assign tty_valid_o = (fill != '0);
  assign pop         = tty_valid_o && tty_ready_i;
  assign push        = tty_we_i && (state == S_RUN) && (!fifo_full || pop);
  assign drop_now    = tty_we_i && (state == S_RUN) && fifo_full && !pop;
  assign tty_data_o  = tty_valid_o ? mem[rd_ptr] : '0;

  // Run control: reset hold sequence, run-cycle counter and verdict flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      dut_rst_no  <= 1'b0;
      cycle_cnt_o <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            dut_rst_no <= 1'b1;
          end else begin
            hold_cnt   <= hold_cnt + HOLD_ONE;
            dut_rst_no <= 1'b0;
          end
        end
        S_RUN: begin
          if (cycle_cnt_o != CNT_MAX) begin
            cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
          end
          // PASS beats FAIL beats the watchdog when they coincide.
          if (led_i == PASS_V) begin
            state      <= S_DONE;
            done_o     <= 1'b1;
            pass_o     <= 1'b1;
            dut_rst_no <= 1'b0;
          end else if (led_i == FAIL_V) begin
            state      <= S_DONE;
            done_o     <= 1'b1;
            dut_rst_no <= 1'b0;
          end else if ((TIMEOUT != 0) && (cycle_cnt_o == TO_LAST)) begin
            state      <= S_DONE;
            done_o     <= 1'b1;
            timeout_o  <= 1'b1;
            dut_rst_no <= 1'b0;
          end else begin
            dut_rst_no <= 1'b1;
          end
        end
        S_DONE: begin
          // Mcu stays frozen; counter and verdict are held until rst_i.
          dut_rst_no <= 1'b0;
        end
        default: begin
          state      <= S_HOLD;
          hold_cnt   <= '0;
          dut_rst_no <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, fill level and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      tty_drop_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
      if (drop_now) begin
        tty_drop_o <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the fill level gates them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= tty_i;
    end
  end

endmodule

// File: tb/tb_mcu_sim_supervisor.sv
`timescale 1ns/1ps
module tb_mcu_sim_supervisor;

  localparam logic [31:0] PASS = 32'h600D_600D;
  localparam logic [31:0] FAILS = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [6:0]  tty;
  logic        tty_we, tty_ready;
  logic [31:0] led, led2;

  logic        dut_rst_no, tty_valid, tty_drop, done, pass, timeout;
  logic [6:0]  tty_data;
  logic [31:0] cycle_cnt;
  logic        dut_rst_no2, tty_valid2, tty_drop2, done2, pass2, timeout2;
  logic [6:0]  tty_data2;
  logic [31:0] cycle_cnt2;

  int tests_run = 0;
  int tests_failed = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_c;

  always #5 clk = ~clk;

  mcu_sim_supervisor dut (
    .clk_i(clk), .rst_i(rst), .dut_rst_no(dut_rst_no), .tty_i(tty), .tty_we_i(tty_we),
    .led_i(led), .tty_data_o(tty_data), .tty_valid_o(tty_valid), .tty_ready_i(tty_ready),
    .tty_drop_o(tty_drop), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .cycle_cnt_o(cycle_cnt)
  );

  mcu_sim_supervisor #(.TIMEOUT(50)) dut2 (
    .clk_i(clk), .rst_i(rst2), .dut_rst_no(dut_rst_no2), .tty_i(tty), .tty_we_i(tty_we),
    .led_i(led2), .tty_data_o(tty_data2), .tty_valid_o(tty_valid2), .tty_ready_i(tty_ready),
    .tty_drop_o(tty_drop2), .done_o(done2), .pass_o(pass2), .timeout_o(timeout2),
    .cycle_cnt_o(cycle_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    rst = 1'b1; rst2 = 1'b1; tty = 7'h00; tty_we = 1'b0; tty_ready = 1'b0;
    led = 32'h0; led2 = 32'h0;
    repeat (2) step();
    tests_run++; if (dut_rst_no !== 1'b0) begin tests_failed++; $display("FAIL reset_rst_no got %0h expected 0", dut_rst_no); end
    tests_run++; if (tty_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0h expected 0", tty_valid); end
    tests_run++; if (tty_data !== 7'h00) begin tests_failed++; $display("FAIL reset_data got %0h expected 0", tty_data); end
    tests_run++; if ({tty_drop, done, pass, timeout} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got %0b expected 0000", {tty_drop, done, pass, timeout}); end
    tests_run++; if (cycle_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_cycle_cnt got %0d expected 0", cycle_cnt); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      e = (k == 5) ? 1'b1 : 1'b0;
      tests_run++; if (dut_rst_no !== e) begin tests_failed++; $display("FAIL hold_edge%0d got %0h expected %0h", k, dut_rst_no, e); end
    end
    tests_run++; if (cycle_cnt !== 32'd0) begin tests_failed++; $display("FAIL run_cnt_start got %0d expected 0", cycle_cnt); end
    step();
    tests_run++; if (cycle_cnt !== 32'd1) begin tests_failed++; $display("FAIL run_cnt_first got %0d expected 1", cycle_cnt); end
  endtask

  task automatic test_tty_hi();
    tty_ready = 1'b1;
    tty_we = 1'b1; tty = 7'h48; exp_q.push_back(7'h48);
    step();
    tty = 7'h69; exp_q.push_back(7'h69);
    tests_run++; if (tty_valid !== 1'b1) begin tests_failed++; $display("FAIL hi_valid1 got %0h expected 1", tty_valid); end
    exp_c = exp_q.pop_front();
    tests_run++; if (tty_data !== exp_c) begin tests_failed++; $display("FAIL hi_char1 got %0h expected %0h", tty_data, exp_c); end
    step();
    tty_we = 1'b0;
    tests_run++; if (tty_valid !== 1'b1) begin tests_failed++; $display("FAIL hi_valid2 got %0h expected 1", tty_valid); end
    exp_c = exp_q.pop_front();
    tests_run++; if (tty_data !== exp_c) begin tests_failed++; $display("FAIL hi_char2 got %0h expected %0h", tty_data, exp_c); end
    step();
    tests_run++; if (tty_valid !== 1'b0) begin tests_failed++; $display("FAIL hi_empty got %0h expected 0", tty_valid); end
  endtask

  task automatic test_overflow();
    int n;
    tty_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tty_we = 1'b1; tty = 7'h10 + 7'(i);
      if (i < 16) exp_q.push_back(tty);
      step();
      if (i == 15) begin
        tests_run++; if (tty_drop !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_drop_at16 got %0h expected 0", tty_drop); end
      end
    end
    tests_run++; if (tty_drop !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop got %0h expected 1", tty_drop); end
    // write and pop together on a full FIFO: both must take effect
    tty_ready = 1'b1; tty = 7'h55; exp_q.push_back(7'h55);
    exp_c = exp_q.pop_front();
    tests_run++; if (tty_data !== exp_c) begin tests_failed++; $display("FAIL ovf_head got %0h expected %0h", tty_data, exp_c); end
    step();
    tty_we = 1'b0;
    n = 0;
    while (tty_valid === 1'b1 && n < 40) begin
      if (exp_q.size() == 0) begin
        tests_run++; tests_failed++; $display("FAIL ovf_extra_char got %0h expected none", tty_data);
      end else begin
        exp_c = exp_q.pop_front();
        tests_run++; if (tty_data !== exp_c) begin tests_failed++; $display("FAIL ovf_drain%0d got %0h expected %0h", n, tty_data, exp_c); end
      end
      step();
      n++;
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ovf_missing got %0d chars left expected 0", exp_q.size()); end
    tests_run++; if (tty_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got %0h expected 0", tty_valid); end
    tests_run++; if (tty_drop !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop_sticky got %0h expected 1", tty_drop); end
    exp_q.delete();
  endtask

  task automatic test_pass();
    int n;
    tty_ready = 1'b0; tty_we = 1'b0;
    n = 0;
    while (cycle_cnt !== 32'd100 && n < 300) begin step(); n++; end
    tests_run++; if (cycle_cnt !== 32'd100) begin tests_failed++; $display("FAIL pass_reach100 got %0d expected 100", cycle_cnt); end
    led = PASS;
    step();
    led = 32'h0;
    tests_run++; if ({done, pass, timeout} !== 3'b110) begin tests_failed++; $display("FAIL pass_flags got %0b expected 110", {done, pass, timeout}); end
    tests_run++; if (dut_rst_no !== 1'b0) begin tests_failed++; $display("FAIL pass_rst_no got %0h expected 0", dut_rst_no); end
    tests_run++; if (cycle_cnt !== 32'd101) begin tests_failed++; $display("FAIL pass_cnt got %0d expected 101", cycle_cnt); end
    tty_we = 1'b1; tty = 7'h33;
    repeat (3) step();
    tty_we = 1'b0;
    tests_run++; if (tty_valid !== 1'b0) begin tests_failed++; $display("FAIL done_we_ignored got %0h expected 0", tty_valid); end
    tests_run++; if (cycle_cnt !== 32'd101) begin tests_failed++; $display("FAIL done_cnt_frozen got %0d expected 101", cycle_cnt); end
    tests_run++; if ({done, pass} !== 2'b11) begin tests_failed++; $display("FAIL done_held got %0b expected 11", {done, pass}); end
  endtask

  task automatic test_timeout();
    int n;
    tests_run++; if ({tty_valid2, tty_drop2, tty_data2} !== 9'h000) begin tests_failed++; $display("FAIL to_fifo_idle got %0h expected 0", {tty_valid2, tty_drop2, tty_data2}); end
    rst2 = 1'b0;
    repeat (5) step();
    tests_run++; if (dut_rst_no2 !== 1'b1) begin tests_failed++; $display("FAIL to_run got %0h expected 1", dut_rst_no2); end
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin step(); n++; end
    tests_run++; if (n != 50) begin tests_failed++; $display("FAIL to_cycles got %0d expected 50", n); end
    tests_run++; if ({done2, pass2, timeout2} !== 3'b101) begin tests_failed++; $display("FAIL to_flags got %0b expected 101", {done2, pass2, timeout2}); end
    tests_run++; if (cycle_cnt2 !== 32'd50) begin tests_failed++; $display("FAIL to_cnt got %0d expected 50", cycle_cnt2); end
    tests_run++; if (dut_rst_no2 !== 1'b0) begin tests_failed++; $display("FAIL to_rst_no got %0h expected 0", dut_rst_no2); end
    // PASS on the same cycle as the watchdog wins
    rst2 = 1'b1; step(); rst2 = 1'b0;
    repeat (5) step();
    n = 0;
    while (cycle_cnt2 !== 32'd49 && n < 200) begin step(); n++; end
    led2 = PASS;
    step();
    led2 = 32'h0;
    tests_run++; if ({done2, pass2, timeout2} !== 3'b110) begin tests_failed++; $display("FAIL to_pass_prio got %0b expected 110", {done2, pass2, timeout2}); end
    // FAIL signature ends the run without pass or timeout
    rst2 = 1'b1; step(); rst2 = 1'b0;
    repeat (5) step();
    repeat (10) step();
    led2 = FAILS;
    step();
    led2 = 32'h0;
    tests_run++; if ({done2, pass2, timeout2} !== 3'b100) begin tests_failed++; $display("FAIL fail_flags got %0b expected 100", {done2, pass2, timeout2}); end
    tests_run++; if (cycle_cnt2 !== 32'd11) begin tests_failed++; $display("FAIL fail_cnt got %0d expected 11", cycle_cnt2); end
  endtask

  task automatic test_midrun_reset();
    logic e;
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      e = (k == 5) ? 1'b1 : 1'b0;
      tests_run++; if (dut_rst_no !== e) begin tests_failed++; $display("FAIL rehold_edge%0d got %0h expected %0h", k, dut_rst_no, e); end
    end
    tests_run++; if (tty_drop !== 1'b0) begin tests_failed++; $display("FAIL rehold_drop got %0h expected 0", tty_drop); end
    tty_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tty_we = 1'b1; tty = 7'h41 + 7'(i);
      step();
    end
    tty_we = 1'b0;
    tests_run++; if (tty_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_buffered got %0h expected 1", tty_valid); end
    rst = 1'b1;
    #1;
    tests_run++; if (dut_rst_no !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_no got %0h expected 0", dut_rst_no); end
    tests_run++; if ({tty_valid, tty_data} !== 8'h00) begin tests_failed++; $display("FAIL mid_fifo got %0h expected 0", {tty_valid, tty_data}); end
    tests_run++; if (cycle_cnt !== 32'd0) begin tests_failed++; $display("FAIL mid_cnt got %0d expected 0", cycle_cnt); end
    tests_run++; if ({done, pass, timeout} !== 3'b000) begin tests_failed++; $display("FAIL mid_flags got %0b expected 000", {done, pass, timeout}); end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      e = (k == 5) ? 1'b1 : 1'b0;
      tests_run++; if (dut_rst_no !== e) begin tests_failed++; $display("FAIL mid_hold_edge%0d got %0h expected %0h", k, dut_rst_no, e); end
    end
    tty_ready = 1'b1; tty_we = 1'b1; tty = 7'h5A; exp_q.push_back(7'h5A);
    step();
    tty_we = 1'b0;
    exp_c = exp_q.pop_front();
    tests_run++; if (tty_valid !== 1'b1 || tty_data !== exp_c) begin tests_failed++; $display("FAIL mid_first_char got %0h expected %0h", tty_data, exp_c); end
    step();
    tests_run++; if (tty_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_empty got %0h expected 0", tty_valid); end
  endtask

  initial begin
    test_reset();
    test_tty_hi();
    test_overflow();
    test_pass();
    test_timeout();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
